// File: rtl/lc3_isdu_param.sv
// SLC-3 instruction sequencer/decoder with configurable memory wait counts,
// an optional Mem_Ready handshake, and LD/ST/LDI/STI/LEA/JSR support.
//
// state     | meaning
// HALTED    | idle, all outputs low, waits for Run
// FETCH     | MAR <- PC, PC <- PC+1
// RD_IR     | SRAM read of the instruction word
// LOADIR    | IR <- MDR
// DECODE    | BEN load, dispatch on opcode
// ALU       | ADD/AND/NOT execute
// BR_CHK    | branch test on BEN
// BR_TAKE   | PC <- PC + off9
// JMP       | PC <- SR1
// JSR       | R7 <- PC and PC <- target in one cycle
// ADDR_B    | MAR <- SR1 + off6
// ADDR_P    | MAR <- PC + off9
// RD_I      | SRAM read of the indirect pointer
// INDIR     | MAR <- MDR
// RD_D      | SRAM read of load data
// WB        | DR <- MDR, set CC
// SRC       | MDR <- SR (store data)
// WR        | SRAM write
// LEA       | DR <- PC + off9
// PAUSE1    | LED load, wait for Continue high
// PAUSE2    | wait for Continue low
module lc3_isdu_param #(
    parameter int unsigned RD_WAIT   = 3,
    parameter int unsigned WR_WAIT   = 3,
    parameter bit          USE_READY = 1'b0,
    parameter bit          PAUSE_EN  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic       i_continue,
    input  logic [3:0] i_opcode,
    input  logic       i_ir_5,
    input  logic       i_ir_11,
    input  logic       i_ben,
    input  logic       i_mem_ready,
    output logic       o_ld_mar,
    output logic       o_ld_mdr,
    output logic       o_ld_ir,
    output logic       o_ld_ben,
    output logic       o_ld_cc,
    output logic       o_ld_reg,
    output logic       o_ld_pc,
    output logic       o_ld_led,
    output logic       o_gate_pc,
    output logic       o_gate_mdr,
    output logic       o_gate_alu,
    output logic       o_gate_marmux,
    output logic [1:0] o_pcmux,
    output logic       o_drmux,
    output logic       o_sr1mux,
    output logic       o_sr2mux,
    output logic       o_addr1mux,
    output logic [1:0] o_addr2mux,
    output logic [1:0] o_aluk,
    output logic       o_mem_oe,
    output logic       o_mem_we,
    output logic       o_instr_done
);

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH, S_RD_IR, S_LOADIR, S_DECODE, S_ALU, S_BR_CHK,
        S_BR_TAKE, S_JMP, S_JSR, S_ADDR_B, S_ADDR_P, S_RD_I, S_INDIR,
        S_RD_D, S_WB, S_SRC, S_WR, S_LEA, S_PAUSE1, S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                           OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                           OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                           OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                           OP_PSE = 4'b1101, OP_LEA = 4'b1110;
    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

    state_t     r_state, w_next;
    logic [3:0] r_cnt;
    logic       w_is_rd, w_is_wr, w_rd_last, w_wr_last, w_is_load;

    assign w_is_rd   = (r_state == S_RD_IR) || (r_state == S_RD_I) || (r_state == S_RD_D);
    assign w_is_wr   = (r_state == S_WR);
    assign w_rd_last = USE_READY ? i_mem_ready : (r_cnt == RD_LAST);
    assign w_wr_last = USE_READY ? i_mem_ready : (r_cnt == WR_LAST);
    assign w_is_load = (i_opcode == OP_LDR) || (i_opcode == OP_LD) || (i_opcode == OP_LDI);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_HALTED;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            // The count is zero whenever no memory state is continuing, so each entry starts fresh.
            if (!USE_READY && ((w_is_rd && !w_rd_last) || (w_is_wr && !w_wr_last)))
                r_cnt <= r_cnt + 4'd1;
            else
                r_cnt <= 4'd0;
        end
    end

    always_comb begin
        w_next        = r_state;
        o_ld_mar      = 1'b0;
        o_ld_mdr      = 1'b0;
        o_ld_ir       = 1'b0;
        o_ld_ben      = 1'b0;
        o_ld_cc       = 1'b0;
        o_ld_reg      = 1'b0;
        o_ld_pc       = 1'b0;
        o_ld_led      = 1'b0;
        o_gate_pc     = 1'b0;
        o_gate_mdr    = 1'b0;
        o_gate_alu    = 1'b0;
        o_gate_marmux = 1'b0;
        o_pcmux       = 2'b00;
        o_drmux       = 1'b0;
        o_sr1mux      = 1'b0;
        o_sr2mux      = 1'b0;
        o_addr1mux    = 1'b0;
        o_addr2mux    = 2'b00;
        o_aluk        = 2'b00;
        o_mem_oe      = 1'b0;
        o_mem_we      = 1'b0;
        o_instr_done  = 1'b0;

        case (r_state)
            S_HALTED: if (i_run) w_next = S_FETCH;
            S_FETCH: begin
                o_gate_pc = 1'b1;
                o_ld_mar  = 1'b1;
                o_ld_pc   = 1'b1;
                w_next    = S_RD_IR;
            end
            S_RD_IR, S_RD_I, S_RD_D: begin
                o_mem_oe = 1'b1;
                if (w_rd_last) begin
                    o_ld_mdr = 1'b1;
                    w_next   = (r_state == S_RD_IR) ? S_LOADIR :
                               (r_state == S_RD_I)  ? S_INDIR  : S_WB;
                end
            end
            S_LOADIR: begin
                o_gate_mdr = 1'b1;
                o_ld_ir    = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                o_ld_ben = 1'b1;
                case (i_opcode)
                    OP_ADD, OP_AND, OP_NOT:         w_next = S_ALU;
                    OP_BR:                          w_next = S_BR_CHK;
                    OP_JMP:                         w_next = S_JMP;
                    OP_JSR:                         w_next = S_JSR;
                    OP_LDR, OP_STR:                 w_next = S_ADDR_B;
                    OP_LD, OP_ST, OP_LDI, OP_STI:   w_next = S_ADDR_P;
                    OP_LEA:                         w_next = S_LEA;
                    OP_PSE:                         w_next = PAUSE_EN ? S_PAUSE1 : S_FETCH;
                    default:                        w_next = S_FETCH;
                endcase
            end
            S_ALU: begin
                o_aluk     = (i_opcode == OP_AND) ? 2'b01 : (i_opcode == OP_NOT) ? 2'b10 : 2'b00;
                o_sr2mux   = i_ir_5;
                o_drmux    = 1'b1;
                o_gate_alu = 1'b1;
                o_ld_reg   = 1'b1;
                o_ld_cc    = 1'b1;
                w_next     = S_FETCH;
            end
            S_BR_CHK: w_next = i_ben ? S_BR_TAKE : S_FETCH;
            S_BR_TAKE: begin
                o_pcmux    = 2'b01;
                o_addr2mux = 2'b10;
                o_ld_pc    = 1'b1;
                w_next     = S_FETCH;
            end
            S_JMP: begin
                o_pcmux    = 2'b01;
                o_addr1mux = 1'b1;
                o_ld_pc    = 1'b1;
                w_next     = S_FETCH;
            end
            S_JSR: begin
                // R7 captures the old PC off the bus while PC loads the target through the adder.
                o_gate_pc  = 1'b1;
                o_ld_reg   = 1'b1;
                o_ld_pc    = 1'b1;
                o_pcmux    = 2'b01;
                o_addr1mux = ~i_ir_11;
                o_addr2mux = i_ir_11 ? 2'b11 : 2'b00;
                w_next     = S_FETCH;
            end
            S_ADDR_B: begin
                o_ld_mar      = 1'b1;
                o_gate_marmux = 1'b1;
                o_addr1mux    = 1'b1;
                o_addr2mux    = 2'b01;
                w_next        = w_is_load ? S_RD_D : S_SRC;
            end
            S_ADDR_P: begin
                o_ld_mar      = 1'b1;
                o_gate_marmux = 1'b1;
                o_addr2mux    = 2'b10;
                w_next        = (i_opcode == OP_LDI || i_opcode == OP_STI) ? S_RD_I :
                                w_is_load ? S_RD_D : S_SRC;
            end
            S_INDIR: begin
                o_gate_mdr = 1'b1;
                o_ld_mar   = 1'b1;
                w_next     = w_is_load ? S_RD_D : S_SRC;
            end
            S_WB: begin
                o_gate_mdr = 1'b1;
                o_drmux    = 1'b1;
                o_ld_reg   = 1'b1;
                o_ld_cc    = 1'b1;
                w_next     = S_FETCH;
            end
            S_SRC: begin
                o_aluk     = 2'b11;
                o_sr1mux   = 1'b1;
                o_gate_alu = 1'b1;
                o_ld_mdr   = 1'b1;
                w_next     = S_WR;
            end
            S_WR: begin
                o_mem_we = 1'b1;
                if (w_wr_last) w_next = S_FETCH;
            end
            S_LEA: begin
                o_gate_marmux = 1'b1;
                o_addr2mux    = 2'b10;
                o_drmux       = 1'b1;
                o_ld_reg      = 1'b1;
                w_next        = S_FETCH;
            end
            S_PAUSE1: begin
                o_ld_led = 1'b1;
                if (i_continue) w_next = S_PAUSE2;
            end
            S_PAUSE2: if (!i_continue) w_next = S_FETCH;
            default: w_next = S_HALTED;
        endcase

        o_instr_done = (w_next == S_FETCH) && (r_state != S_HALTED);
    end

endmodule
